// File: rtl/ok_cmd_pkg.sv
// ============================================================================
// Module      : ok_cmd_pkg
// Description : Field positions, status layout and command type shared by
//               the WireIn command queue and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ok_cmd_pkg;

    // Command word layout on the WireIn
    localparam int SEQ_BIT  = 31;
    localparam int OP_MSB   = 30;
    localparam int OP_LSB   = 28;
    localparam int ADDR_MSB = 27;
    localparam int ADDR_LSB = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;

    // Status word layout for the companion WireOut
    localparam int ST_OVF_BIT   = 31;
    localparam int ST_ARMED_BIT = 30;
    localparam int ST_ERR_MSB   = 23;
    localparam int ST_ERR_LSB   = 16;
    localparam int ST_LVL_MSB   = 5;
    localparam int ST_LVL_LSB   = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [15:0] data;
    } ok_cmd_t;

    localparam int CMD_W = $bits(ok_cmd_t);

    typedef enum logic [0:0] {
        ARM_IDLE = 1'b0,
        ARM_LIVE = 1'b1
    } arm_state_t;

endpackage

`default_nettype wire

// File: rtl/ok_cmd_fifo.sv
// ============================================================================
// Module      : ok_cmd_fifo
// Description : Generic synchronous FIFO, 2**DEPTH_LOG2 entries, combinational
//               head read, extra pointer bit distinguishes full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ok_cmd_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                w_do_push;
    logic                w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= din;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ok_wire_cmd_queue.sv
// ============================================================================
// Module      : ok_wire_cmd_queue
// Description : Turns SEQ-toggled WireIn writes into queued valid/ready
//               commands and exports a registered status word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ok_wire_cmd_queue
    import ok_cmd_pkg::*;
#(
    parameter int DEPTH_LOG2  = 2,
    parameter int OP_RESERVED = 7
) (
    input  logic        okClk,
    input  logic        okRst_n,
    input  logic [31:0] wire_in,
    input  logic        clr_status,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [11:0] cmd_addr,
    output logic [15:0] cmd_data,
    output logic [31:0] status
);

    arm_state_t          r_arm_state;
    arm_state_t          w_arm_next;
    logic                r_seq_ref;
    logic                r_capture;
    ok_cmd_t             r_cap_cmd;
    logic [7:0]          r_err_cnt;
    logic                r_overflow;
    logic [31:0]         r_status;
    logic [31:0]         w_status_next;

    logic                w_armed;
    logic                w_toggle;
    logic                w_pop;
    logic                w_reserved;
    logic                w_overflow_ev;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic [DEPTH_LOG2:0] w_level;
    ok_cmd_t             w_head;

    // ------------------------------------------------------------------
    // Arming: one idle cycle after reset to latch the current SEQ
    // ------------------------------------------------------------------
    always_ff @(posedge okClk) begin
        if (!okRst_n) begin
            r_arm_state <= ARM_IDLE;
        end else begin
            r_arm_state <= w_arm_next;
        end
    end

    always_comb begin
        w_arm_next = r_arm_state;
        case (r_arm_state)
            ARM_IDLE: w_arm_next = ARM_LIVE;
            ARM_LIVE: w_arm_next = ARM_LIVE;
            default:  w_arm_next = ARM_IDLE;
        endcase
    end

    assign w_armed  = (r_arm_state == ARM_LIVE);
    assign w_toggle = w_armed && (wire_in[SEQ_BIT] != r_seq_ref);

    // seq_ref simply follows the wire: it only differs on a toggle cycle
    always_ff @(posedge okClk) begin
        if (!okRst_n) begin
            r_seq_ref <= 1'b0;
            r_capture <= 1'b0;
            r_cap_cmd <= '0;
        end else begin
            r_seq_ref <= wire_in[SEQ_BIT];
            r_capture <= w_toggle;
            if (w_toggle) begin
                r_cap_cmd.op   <= wire_in[OP_MSB:OP_LSB];
                r_cap_cmd.addr <= wire_in[ADDR_MSB:ADDR_LSB];
                r_cap_cmd.data <= wire_in[DATA_MSB:DATA_LSB];
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture filter and queue
    // ------------------------------------------------------------------
    assign cmd_valid     = !w_empty;
    assign w_pop         = cmd_valid && cmd_ready;
    assign w_reserved    = r_capture && (r_cap_cmd.op == 3'(OP_RESERVED));
    assign w_overflow_ev = r_capture && !w_reserved && w_full && !w_pop;
    assign w_push        = r_capture && !w_reserved && !w_overflow_ev;

    ok_cmd_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (CMD_W)
    ) u_fifo (
        .clk   (okClk),
        .rst_n (okRst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_cap_cmd),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign cmd_op   = w_head.op;
    assign cmd_addr = w_head.addr;
    assign cmd_data = w_head.data;

    // ------------------------------------------------------------------
    // Error bookkeeping: a same-cycle event beats clr_status
    // ------------------------------------------------------------------
    always_ff @(posedge okClk) begin
        if (!okRst_n) begin
            r_err_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_reserved) begin
                if (clr_status) begin
                    r_err_cnt <= 8'd1;
                end else if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else if (clr_status) begin
                r_err_cnt <= '0;
            end

            if (w_overflow_ev) begin
                r_overflow <= 1'b1;
            end else if (clr_status) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status_next                          = '0;
        w_status_next[ST_OVF_BIT]              = r_overflow;
        w_status_next[ST_ARMED_BIT]            = w_armed;
        w_status_next[ST_ERR_MSB:ST_ERR_LSB]   = r_err_cnt;
        w_status_next[ST_LVL_MSB:ST_LVL_LSB]   = 6'(w_level);
    end

    always_ff @(posedge okClk) begin
        if (!okRst_n) begin
            r_status <= '0;
        end else begin
            r_status <= w_status_next;
        end
    end

    assign status = r_status;

endmodule

`default_nettype wire

// File: tb/tb_ok_wire_cmd_queue.sv
// ============================================================================
// Module      : tb_ok_wire_cmd_queue
// Description : Scoreboard bench for ok_wire_cmd_queue with a behavioural
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ok_wire_cmd_queue;

    localparam int DEPTH = 4;

    logic        okClk;
    logic        okRst_n;
    logic [31:0] wire_in;
    logic        clr_status;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [11:0] cmd_addr;
    logic [15:0] cmd_data;
    logic [31:0] status;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;

    ok_wire_cmd_queue #(
        .DEPTH_LOG2  (2),
        .OP_RESERVED (7)
    ) dut (
        .okClk      (okClk),
        .okRst_n    (okRst_n),
        .wire_in    (wire_in),
        .clr_status (clr_status),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .status     (status)
    );

    initial okClk = 1'b0;
    always #5 okClk = ~okClk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: spec rules expressed with counters and a queue
    // ------------------------------------------------------------------
    logic [30:0] exp_q[$];
    bit          m_armed, m_seq, m_cap, m_ovf;
    logic [31:0] m_cap_word;
    logic [31:0] m_status;
    int          m_level, m_err;

    always @(posedge okClk) begin
        bit pop, ev_err, ev_ovf;
        if (!okRst_n) begin
            m_armed = 0; m_seq = 0; m_cap = 0; m_ovf = 0;
            m_level = 0; m_err = 0; m_status = '0; m_cap_word = '0;
            exp_q.delete();
        end else begin
            m_status = {m_ovf, m_armed, 6'b0, 8'(m_err), 10'b0, 6'(m_level)};
            pop    = cmd_ready && (m_level > 0);
            ev_err = 0;
            ev_ovf = 0;
            if (m_cap) begin
                if (m_cap_word[30:28] == 3'd7) ev_err = 1;
                else if (m_level == DEPTH && !pop) ev_ovf = 1;
                else begin
                    exp_q.push_back(m_cap_word[30:0]);
                    m_level++;
                end
            end
            if (pop) m_level--;
            if (ev_err) m_err = clr_status ? 1 : ((m_err == 255) ? 255 : m_err + 1);
            else if (clr_status) m_err = 0;
            if (ev_ovf) m_ovf = 1;
            else if (clr_status) m_ovf = 0;
            if (!m_armed) begin
                m_seq   = wire_in[31];
                m_armed = 1;
                m_cap   = 0;
            end else begin
                m_cap = (wire_in[31] != m_seq);
                if (m_cap) begin
                    m_cap_word = wire_in;
                    m_seq      = wire_in[31];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: samples 2 time units before the active edge
    // ------------------------------------------------------------------
    always @(negedge okClk) begin
        logic [30:0] head;
        if (mon_en) begin
            #3;
            head = {cmd_op, cmd_addr, cmd_data};
            chk("valid_vs_model", {31'b0, cmd_valid}, {31'b0, m_level > 0});
            chk("status_vs_model", status, m_status);
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL head_unexpected: got %h expected no command at %0t", head, $time);
                end else begin
                    chk("head_vs_scoreboard", {1'b0, head}, {1'b0, exp_q[0]});
                    if (cmd_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic toggle(input logic [31:0] p);
        wire_in = {~wire_in[31], p[30:0]};
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge okClk);
    endtask

    task automatic clr_pulse();
        @(negedge okClk);
        clr_status = 1'b1;
        @(negedge okClk);
        clr_status = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        okRst_n    = 1'b0;
        wire_in    = 32'h8000_0000;
        clr_status = 1'b0;
        cmd_ready  = 1'b0;
        cycles(3);
        chk("reset_status", status, 32'h0);
        chk("reset_valid", {31'b0, cmd_valid}, 32'h0);
        chk("reset_head", {1'b0, cmd_op, cmd_addr, cmd_data}, 32'h0);
        okRst_n = 1'b1;
        mon_en  = 1'b1;

        // 1: arm with SEQ already high, no command
        cycles(2);
        chk("t1_armed_status", status, 32'h4000_0000);
        chk("t1_no_valid", {31'b0, cmd_valid}, 32'h0);

        // 2: single command latency
        cmd_ready = 1'b1;
        toggle(32'h1123_BEEF);
        cycles(1);
        chk("t2_valid_n1", {31'b0, cmd_valid}, 32'h0);
        cycles(1);
        chk("t2_valid_n2", {31'b0, cmd_valid}, 32'h1);
        chk("t2_op", {29'b0, cmd_op}, 32'h1);
        chk("t2_addr", {20'b0, cmd_addr}, 32'h123);
        chk("t2_data", {16'b0, cmd_data}, 32'hBEEF);
        cycles(1);
        chk("t2_pulse_end", {31'b0, cmd_valid}, 32'h0);

        // 3: overflow with backpressure
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            toggle({1'b0, 3'(i % 4), 12'(16 + i), 16'(16'hA000 + i)});
            cycles(1);
        end
        cycles(3);
        chk("t3_full_ovf", status, 32'hC000_0004);
        cmd_ready = 1'b1;
        cycles(6);
        chk("t3_drained", status, 32'hC000_0000);
        cmd_ready = 1'b0;
        clr_pulse();
        cycles(2);
        chk("t3_ovf_cleared", status, 32'h4000_0000);

        // 4: reserved opcode
        toggle(32'hF000_0001);
        cycles(4);
        chk("t4_err1", status, 32'h4001_0000);
        chk("t4_not_queued", {31'b0, cmd_valid}, 32'h0);
        clr_pulse();
        cycles(2);
        chk("t4_err_cleared", status, 32'h4000_0000);

        // 5: push into a full FIFO alongside a pop
        for (int i = 0; i < 4; i++) begin
            toggle({1'b0, 3'(i), 12'(32 + i), 16'(16'h5000 + i)});
            cycles(1);
        end
        cycles(3);
        chk("t5_full", status, 32'h4000_0004);
        toggle(32'h0555_1234);
        cycles(1);
        cmd_ready = 1'b1;
        cycles(1);
        cmd_ready = 1'b0;
        cycles(3);
        chk("t5_still_full_no_ovf", status, 32'h4000_0004);
        cmd_ready = 1'b1;
        cycles(6);
        cmd_ready = 1'b0;

        // 6: reset with queued commands, no replay afterwards
        for (int i = 0; i < 3; i++) begin
            toggle({1'b0, 3'(i + 2), 12'(64 + i), 16'(16'h6000 + i)});
            cycles(1);
        end
        cycles(3);
        chk("t6_queued3", status, 32'h4000_0003);
        okRst_n = 1'b0;
        cycles(1);
        okRst_n = 1'b1;
        chk("t6_flushed_valid", {31'b0, cmd_valid}, 32'h0);
        chk("t6_flushed_status", status, 32'h0);
        cycles(5);
        chk("t6_rearmed", status, 32'h4000_0000);
        chk("t6_no_replay", {31'b0, cmd_valid}, 32'h0);

        // error counter saturation
        for (int i = 0; i < 300; i++) begin
            toggle(32'h7000_0000 | ($urandom() & 32'h0FFF_FFFF));
            cycles(1);
        end
        cycles(4);
        chk("sat_err_ff", status, 32'h40FF_0000);
        clr_pulse();
        cycles(2);
        chk("sat_cleared", status, 32'h4000_0000);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            cmd_ready  = ($urandom_range(0, 1) == 1);
            clr_status = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0, 1:    toggle($urandom());
                2:       wire_in[30:0] = 31'($urandom());
                default: ;
            endcase
            cycles(1);
        end
        clr_status = 1'b0;
        cmd_ready  = 1'b1;
        cycles(10);
        chk("final_empty", {31'b0, cmd_valid}, 32'h0);
        chk("final_scoreboard_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
